// File: rtl/rom_dl_router.sv
// ROM download router: steers the HPS download stream into the program/character
// ROM write ports, tracks per-region counts and checksums, and sequences the core reset.
module rom_dl_router #(
    parameter int PRG_AW   = 16,
    parameter int CHR_AW   = 16,
    parameter int HOLD_CYC = 16
) (
    input  logic              ROMCL,
    input  logic              RESET_N,
    input  logic              DLACT,
    input  logic              ROMEN,
    input  logic [24:0]       ROMAD,
    input  logic [7:0]        ROMDT,
    output logic              PRG_WE,
    output logic [PRG_AW-1:0] PRG_AD,
    output logic              CHR_WE,
    output logic [CHR_AW-1:0] CHR_AD,
    output logic [7:0]        WDT,
    output logic              CORE_RST,
    output logic              DL_DONE,
    output logic              DL_ERR,
    output logic [7:0]        PRG_SUM,
    output logic [7:0]        CHR_SUM
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam logic [25:0]       PRG_SIZE    = 26'd1 << PRG_AW;
    localparam logic [25:0]       CHR_END     = PRG_SIZE + (26'd1 << CHR_AW);
    localparam logic [CHR_AW-1:0] CHR_BASE_LO = CHR_AW'(PRG_SIZE);
    localparam logic [PRG_AW:0]   PRG_FULL    = {1'b1, {PRG_AW{1'b0}}};
    localparam logic [CHR_AW:0]   CHR_FULL    = {1'b1, {CHR_AW{1'b0}}};
    localparam logic [15:0]       HOLD_INIT   = 16'(HOLD_CYC - 1);

    logic [1:0]        state, state_nxt;
    logic [15:0]       hold_cnt;
    logic [PRG_AW:0]   prg_cnt, prg_cnt_nxt;
    logic [CHR_AW:0]   chr_cnt, chr_cnt_nxt;
    logic [7:0]        prg_sum_nxt, chr_sum_nxt;
    logic              err_nxt;
    logic [25:0]       addr_ext;
    logic              accept, in_prg, in_chr, hit_prg, hit_chr, hit_bad;
    logic              enter_load, load_end;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        addr_ext   = {1'b0, ROMAD};
        in_prg     = addr_ext < PRG_SIZE;
        in_chr     = !in_prg && (addr_ext < CHR_END);
        accept     = ROMEN && DLACT && (state == S_EMPTY || state == S_LOAD);
        hit_prg    = accept && in_prg;
        hit_chr    = accept && in_chr;
        hit_bad    = accept && !in_prg && !in_chr;
        load_end   = (state == S_LOAD) && !DLACT;
        state_nxt  = state;
        enter_load = 1'b0;

        case (state)
            S_EMPTY: if (DLACT) begin
                state_nxt  = S_LOAD;
                enter_load = 1'b1;
            end
            S_LOAD: if (!DLACT) state_nxt = S_HOLD;
            S_HOLD: begin
                if (DLACT) begin
                    state_nxt  = S_LOAD;
                    enter_load = 1'b1;
                end else if (hold_cnt == 16'd0) begin
                    state_nxt = DL_ERR ? S_EMPTY : S_RUN;
                end
            end
            default: if (DLACT) begin
                state_nxt  = S_LOAD;
                enter_load = 1'b1;
            end
        endcase

        // Entering LOAD clears the statistics; EMPTY's first accepted byte lands on top of that.
        prg_cnt_nxt = enter_load ? '0 : prg_cnt;
        chr_cnt_nxt = enter_load ? '0 : chr_cnt;
        prg_sum_nxt = (enter_load ? 8'd0 : PRG_SUM) + (hit_prg ? ROMDT : 8'd0);
        chr_sum_nxt = (enter_load ? 8'd0 : CHR_SUM) + (hit_chr ? ROMDT : 8'd0);
        if (hit_prg && prg_cnt_nxt != PRG_FULL) prg_cnt_nxt = prg_cnt_nxt + (PRG_AW+1)'(1);
        if (hit_chr && chr_cnt_nxt != CHR_FULL) chr_cnt_nxt = chr_cnt_nxt + (CHR_AW+1)'(1);

        err_nxt = enter_load ? 1'b0 : DL_ERR;
        if (hit_bad) err_nxt = 1'b1;
        // Counters saturate at the region size, so "below size" is simply "not full".
        if (load_end && (prg_cnt != PRG_FULL || chr_cnt != CHR_FULL)) err_nxt = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ROMCL or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_EMPTY;
            hold_cnt <= '0;
            prg_cnt  <= '0;
            chr_cnt  <= '0;
            PRG_WE   <= 1'b0;
            PRG_AD   <= '0;
            CHR_WE   <= 1'b0;
            CHR_AD   <= '0;
            WDT      <= '0;
            CORE_RST <= 1'b1;
            DL_DONE  <= 1'b0;
            DL_ERR   <= 1'b0;
            PRG_SUM  <= '0;
            CHR_SUM  <= '0;
        end else begin
            state    <= state_nxt;
            prg_cnt  <= prg_cnt_nxt;
            chr_cnt  <= chr_cnt_nxt;
            PRG_SUM  <= prg_sum_nxt;
            CHR_SUM  <= chr_sum_nxt;
            DL_ERR   <= err_nxt;
            PRG_WE   <= hit_prg;
            CHR_WE   <= hit_chr;
            CORE_RST <= (state_nxt != S_RUN);
            DL_DONE  <= (state == S_HOLD) && (state_nxt == S_RUN);

            if (hit_prg)             PRG_AD <= ROMAD[PRG_AW-1:0];
            if (hit_chr)             CHR_AD <= ROMAD[CHR_AW-1:0] - CHR_BASE_LO;
            if (hit_prg || hit_chr)  WDT    <= ROMDT;

            if (load_end)
                hold_cnt <= HOLD_INIT;
            else if (state == S_HOLD && hold_cnt != 16'd0)
                hold_cnt <= hold_cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router: write strobes are scoreboarded against a queue of
// expected writes; status outputs are checked at fixed points of each download.
module tb_rom_dl_router;

    localparam int PRG_AW   = 4;
    localparam int CHR_AW   = 4;
    localparam int HOLD_CYC = 3;

    logic              ROMCL = 1'b0;
    logic              RESET_N, DLACT, ROMEN;
    logic [24:0]       ROMAD;
    logic [7:0]        ROMDT;
    logic              PRG_WE, CHR_WE, CORE_RST, DL_DONE, DL_ERR;
    logic [PRG_AW-1:0] PRG_AD;
    logic [CHR_AW-1:0] CHR_AD;
    logic [7:0]        WDT, PRG_SUM, CHR_SUM;

    rom_dl_router #(.PRG_AW(PRG_AW), .CHR_AW(CHR_AW), .HOLD_CYC(HOLD_CYC)) dut (
        .ROMCL(ROMCL), .RESET_N(RESET_N), .DLACT(DLACT), .ROMEN(ROMEN),
        .ROMAD(ROMAD), .ROMDT(ROMDT), .PRG_WE(PRG_WE), .PRG_AD(PRG_AD),
        .CHR_WE(CHR_WE), .CHR_AD(CHR_AD), .WDT(WDT), .CORE_RST(CORE_RST),
        .DL_DONE(DL_DONE), .DL_ERR(DL_ERR), .PRG_SUM(PRG_SUM), .CHR_SUM(CHR_SUM)
    );

    always #5 ROMCL = ~ROMCL;

    typedef struct {
        bit         is_prg;
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t sb[$];
    int  cyc    = 0;
    int  n_asrt = 0;
    int  n_fail = 0;

    always @(posedge ROMCL) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: each strobe must match the oldest expected write, on its expected cycle.
    wr_t mon_e;
    always @(negedge ROMCL) begin
        if (RESET_N) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("missed_strobe_cycle", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (PRG_WE || CHR_WE) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {30'b0, PRG_WE, CHR_WE}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("we_bits", {30'b0, PRG_WE, CHR_WE}, mon_e.is_prg ? 32'd2 : 32'd1);
                    check("wr_addr", mon_e.is_prg ? 32'(PRG_AD) : 32'(CHR_AD), 32'(mon_e.addr));
                    check("wr_data", WDT, mon_e.data);
                    check("wr_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    // One ROMEN cycle; acc says whether the DUT should accept it given DLACT and the FSM state.
    task automatic do_write(input int a, input logic [7:0] d, input bit acc);
        wr_t e;
        ROMEN = 1'b1;
        ROMAD = 25'(a);
        ROMDT = d;
        if (acc && a < 32) begin
            e.is_prg = (a < 16);
            e.addr   = (a < 16) ? 4'(a) : 4'(a - 16);
            e.data   = d;
            e.cyc    = cyc + 1;
            sb.push_back(e);
        end
        @(negedge ROMCL);
        ROMEN = 1'b0;
    endtask

    task automatic full_load(input logic [7:0] d);
        for (int a = 0; a < 32; a++) do_write(a, d, 1'b1);
    endtask

    // Drops DLACT and follows the HOLD countdown through to its outcome.
    task automatic end_load(input bit clean, input logic [7:0] ps, input logic [7:0] cs,
                            input string tag);
        DLACT = 1'b0;
        @(negedge ROMCL);
        check({tag, "_prg_sum"}, PRG_SUM, ps);
        check({tag, "_chr_sum"}, CHR_SUM, cs);
        check({tag, "_err"}, DL_ERR, !clean);
        check({tag, "_rst_hold0"}, CORE_RST, 1'b1);
        check({tag, "_done_hold0"}, DL_DONE, 1'b0);
        for (int i = 1; i < HOLD_CYC; i++) begin
            @(negedge ROMCL);
            check({tag, "_rst_hold"}, CORE_RST, 1'b1);
            check({tag, "_done_hold"}, DL_DONE, 1'b0);
        end
        @(negedge ROMCL);
        check({tag, "_rst_end"}, CORE_RST, !clean);
        check({tag, "_done_end"}, DL_DONE, clean);
        @(negedge ROMCL);
        check({tag, "_rst_after"}, CORE_RST, !clean);
        check({tag, "_done_after"}, DL_DONE, 1'b0);
    endtask

    initial begin
        RESET_N = 1'b0;
        DLACT   = 1'b0;
        ROMEN   = 1'b0;
        ROMAD   = '0;
        ROMDT   = '0;
        repeat (2) @(negedge ROMCL);
        check("rst_core_rst", CORE_RST, 1'b1);
        check("rst_prg_we", PRG_WE, 1'b0);
        check("rst_chr_we", CHR_WE, 1'b0);
        check("rst_prg_ad", PRG_AD, 4'h0);
        check("rst_chr_ad", CHR_AD, 4'h0);
        check("rst_wdt", WDT, 8'h00);
        check("rst_done", DL_DONE, 1'b0);
        check("rst_err", DL_ERR, 1'b0);
        check("rst_prg_sum", PRG_SUM, 8'h00);
        check("rst_chr_sum", CHR_SUM, 8'h00);
        RESET_N = 1'b1;
        @(negedge ROMCL);
        check("empty_core_rst", CORE_RST, 1'b1);

        // Clean load from EMPTY: DLACT and the first strobe arrive together.
        DLACT = 1'b1;
        full_load(8'h01);
        end_load(1'b1, 8'h10, 8'h10, "clean");

        // ROMEN without DLACT is ignored.
        do_write(5, 8'hAA, 1'b0);
        check("nodl_prg_we", PRG_WE, 1'b0);
        check("nodl_prg_sum", PRG_SUM, 8'h10);
        check("nodl_core_rst", CORE_RST, 1'b0);

        // Reload from RUN with 0xFF bytes.
        DLACT = 1'b1;
        @(negedge ROMCL);
        check("reload_core_rst", CORE_RST, 1'b1);
        check("reload_prg_sum", PRG_SUM, 8'h00);
        check("reload_chr_sum", CHR_SUM, 8'h00);
        check("reload_err", DL_ERR, 1'b0);
        full_load(8'hFF);
        end_load(1'b1, 8'hF0, 8'hF0, "reload");

        // Short load: addresses 0..20 only.
        DLACT = 1'b1;
        @(negedge ROMCL);
        for (int a = 0; a <= 20; a++) do_write(a, 8'h01, 1'b1);
        end_load(1'b0, 8'h10, 8'h05, "short");
        repeat (3) begin
            @(negedge ROMCL);
            check("short_rst_stays", CORE_RST, 1'b1);
            check("short_no_done", DL_DONE, 1'b0);
        end

        // Out-of-range write from EMPTY; the previous error clears on entry.
        DLACT = 1'b1;
        do_write(0, 8'h01, 1'b1);
        check("oor_err_cleared", DL_ERR, 1'b0);
        for (int a = 1; a < 32; a++) do_write(a, 8'h01, 1'b1);
        check("oor_err_before", DL_ERR, 1'b0);
        do_write(32, 8'h7E, 1'b0);
        check("oor_err_set", DL_ERR, 1'b1);
        check("oor_prg_we", PRG_WE, 1'b0);
        check("oor_chr_we", CHR_WE, 1'b0);
        end_load(1'b0, 8'h10, 8'h10, "oor");

        // Restart in HOLD one cycle after DLACT falls; counters must start over.
        DLACT = 1'b1;
        full_load(8'h01);
        DLACT = 1'b0;
        @(negedge ROMCL);
        DLACT = 1'b1;
        @(negedge ROMCL);
        check("restart_core_rst", CORE_RST, 1'b1);
        check("restart_done", DL_DONE, 1'b0);
        check("restart_prg_sum", PRG_SUM, 8'h00);
        check("restart_chr_sum", CHR_SUM, 8'h00);
        check("restart_err", DL_ERR, 1'b0);
        end_load(1'b0, 8'h00, 8'h00, "restart");

        // Async reset between strobes, with a ROMEN pending while RESET_N is low.
        DLACT = 1'b1;
        for (int a = 0; a < 4; a++) do_write(a, 8'h05, 1'b1);
        ROMEN = 1'b1;
        ROMAD = 25'd4;
        ROMDT = 8'h05;
        #2 RESET_N = 1'b0;
        #1;
        check("arst_prg_we", PRG_WE, 1'b0);
        check("arst_prg_ad", PRG_AD, 4'h0);
        check("arst_wdt", WDT, 8'h00);
        check("arst_prg_sum", PRG_SUM, 8'h00);
        check("arst_core_rst", CORE_RST, 1'b1);
        @(negedge ROMCL);
        check("arst_held_prg_we", PRG_WE, 1'b0);
        check("arst_held_chr_we", CHR_WE, 1'b0);
        check("arst_held_prg_sum", PRG_SUM, 8'h00);
        ROMEN   = 1'b0;
        DLACT   = 1'b0;
        RESET_N = 1'b1;
        @(negedge ROMCL);
        check("arst_rel_core_rst", CORE_RST, 1'b1);

        // Recovery: a clean load straight from EMPTY.
        DLACT = 1'b1;
        full_load(8'h02);
        end_load(1'b1, 8'h20, 8'h20, "final");

        repeat (2) @(negedge ROMCL);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
